// File: rtl/pixel_stream_tx_if.sv
// Stream (vld/eor/eof/data/rdy) and synchronous frame-memory read interfaces for pixel_stream_tx.
interface pixel_stream_if #(
    parameter int DATA_W = 8
) ();
    logic              vld;
    logic              eor;
    logic              eof;
    logic [DATA_W-1:0] data;
    logic              rdy;

    modport master (output vld, eor, eof, data, input rdy);
    modport slave  (input vld, eor, eof, data, output rdy);
endinterface

interface frame_mem_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8
) ();
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rdata;

    modport master (output en, addr, input rdata);
    modport slave  (input en, addr, output rdata);
endinterface

// File: rtl/pixel_stream_tx.sv
// Raster-order frame reader feeding the swsc input stream through a 2-entry fall-through FIFO.
// Optional PIXEL_TX_PATTERN_EN adds i_pat_en: a (col+row) test pattern replaces memory reads.
module pixel_stream_tx #(
    parameter int DATA_W    = 8,
    parameter int MAX_IMG_W = 640,
    parameter int MAX_IMG_H = 480,
    parameter int ADDR_W    = 19,
    localparam int CW       = $clog2(MAX_IMG_W + 1),
    localparam int HW       = $clog2(MAX_IMG_H + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [CW-1:0] i_img_w,
    input  logic [HW-1:0] i_img_h,
`ifdef PIXEL_TX_PATTERN_EN
    input  logic          i_pat_en,
`endif
    frame_mem_if.master   mem,
    pixel_stream_if.master px,
    output logic          o_busy,
    output logic          o_done
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int EW = DATA_W + 2;

    state_t            state_r, state_nxt_s;
    logic [CW-1:0]     img_w_r, col_r;
    logic [HW-1:0]     img_h_r, row_r;
    logic [ADDR_W-1:0] addr_r;
    logic              rd_vld_r, rd_eor_r, rd_eof_r;
    logic [EW-1:0]     fifo_r [2];
    logic              wr_ptr_r, rd_ptr_r;
    logic [1:0]        count_r;
    logic              done_r;

    logic              start_ok_s, zero_dim_s, last_col_s, last_s;
    logic              vld_s, pop_s, push_s, fifo_pop_s, issue_s, eof_pop_s, mem_en_s;
    logic [2:0]        occ_s;
    logic [DATA_W-1:0] in_data_s;
    logic [EW-1:0]     in_entry_s, head_s;

`ifdef PIXEL_TX_PATTERN_EN
    logic              pat_r;
    logic [DATA_W-1:0] rd_pat_r;
    logic [DATA_W-1:0] pat_sum_s;
`endif

    // Read issue, FIFO head selection and handshake decode.
    always_comb begin
        start_ok_s = (state_r == ST_IDLE) && i_start;
        zero_dim_s = (i_img_w == {CW{1'b0}}) || (i_img_h == {HW{1'b0}});
        last_col_s = (col_r == (img_w_r - {{(CW-1){1'b0}}, 1'b1}));
        last_s     = last_col_s && (row_r == (img_h_r - {{(HW-1){1'b0}}, 1'b1}));
`ifdef PIXEL_TX_PATTERN_EN
        pat_sum_s  = DATA_W'(col_r) + DATA_W'(row_r);
        in_data_s  = pat_r ? rd_pat_r : mem.rdata;
`else
        in_data_s  = mem.rdata;
`endif
        in_entry_s = {rd_eof_r, rd_eor_r, in_data_s};
        // Fall-through: an empty FIFO presents the word arriving from memory this cycle.
        if (count_r != 2'd0) begin
            head_s = fifo_r[rd_ptr_r];
        end else if (rd_vld_r) begin
            head_s = in_entry_s;
        end else begin
            head_s = {EW{1'b0}};
        end
        vld_s      = (count_r != 2'd0) || rd_vld_r;
        pop_s      = vld_s && px.rdy;
        fifo_pop_s = pop_s && (count_r != 2'd0);
        push_s     = rd_vld_r && !((count_r == 2'd0) && pop_s);
        occ_s      = {1'b0, count_r} + {2'b00, rd_vld_r} - {2'b00, pop_s};
        issue_s    = (state_r == ST_RUN) && (occ_s < 3'd2);
        eof_pop_s  = (state_r == ST_DRAIN) && pop_s && head_s[EW-1];
`ifdef PIXEL_TX_PATTERN_EN
        mem_en_s   = issue_s && !pat_r;
`else
        mem_en_s   = issue_s;
`endif
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s && !zero_dim_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (issue_s && last_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (eof_pop_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Frame counters, in-flight read tag, FIFO storage and done pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            img_w_r  <= {CW{1'b0}};
            img_h_r  <= {HW{1'b0}};
            col_r    <= {CW{1'b0}};
            row_r    <= {HW{1'b0}};
            addr_r   <= {ADDR_W{1'b0}};
            rd_vld_r <= 1'b0;
            rd_eor_r <= 1'b0;
            rd_eof_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
            done_r   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_r[i] <= {EW{1'b0}};
            end
`ifdef PIXEL_TX_PATTERN_EN
            pat_r    <= 1'b0;
            rd_pat_r <= {DATA_W{1'b0}};
`endif
        end else begin
            done_r <= (start_ok_s && zero_dim_s) || eof_pop_s;
            if (start_ok_s) begin
                img_w_r <= i_img_w;
                img_h_r <= i_img_h;
                col_r   <= {CW{1'b0}};
                row_r   <= {HW{1'b0}};
                addr_r  <= {ADDR_W{1'b0}};
`ifdef PIXEL_TX_PATTERN_EN
                pat_r   <= i_pat_en;
`endif
            end else if (issue_s) begin
                addr_r <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                if (last_col_s) begin
                    col_r <= {CW{1'b0}};
                    row_r <= row_r + {{(HW-1){1'b0}}, 1'b1};
                end else begin
                    col_r <= col_r + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            // Position tags travel alongside the read and meet its data one cycle later.
            rd_vld_r <= issue_s;
            rd_eor_r <= last_col_s;
            rd_eof_r <= last_s;
`ifdef PIXEL_TX_PATTERN_EN
            rd_pat_r <= pat_sum_s;
`endif
            if (push_s) begin
                fifo_r[wr_ptr_r] <= in_entry_s;
                wr_ptr_r         <= ~wr_ptr_r;
            end
            if (fifo_pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r <= count_r + {1'b0, push_s} - {1'b0, fifo_pop_s};
        end
    end

    assign mem.en   = mem_en_s;
    assign mem.addr = mem_en_s ? addr_r : {ADDR_W{1'b0}};
    assign px.vld   = vld_s;
    assign px.eof   = head_s[EW-1];
    assign px.eor   = head_s[EW-2];
    assign px.data  = head_s[DATA_W-1:0];
    assign o_busy   = (state_r != ST_IDLE);
    assign o_done   = done_r;

endmodule

// File: tb/tb_pixel_stream_tx.sv
// Randomized self-checking bench for pixel_stream_tx against a queue-based raster model.
module tb_pixel_stream_tx;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 19;
    localparam int CW     = 10;
    localparam int HW     = 9;

    typedef struct packed {
        logic              eof;
        logic              eor;
        logic [DATA_W-1:0] data;
    } pix_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] img_w = '0;
    logic [HW-1:0] img_h = '0;
    logic          pat_en = 1'b0;
    logic          rdy = 1'b1;
    logic [7:0]    mem_rdata = 8'd0;
    logic          busy, done;

    pixel_stream_if #(.DATA_W(DATA_W)) px_if ();
    frame_mem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

    assign px_if.rdy    = rdy;
    assign mem_if.rdata = mem_rdata;

    pixel_stream_tx #(.DATA_W(DATA_W), .MAX_IMG_W(640), .MAX_IMG_H(480), .ADDR_W(ADDR_W)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_img_w (img_w),
        .i_img_h (img_h),
`ifdef PIXEL_TX_PATTERN_EN
        .i_pat_en(pat_en),
`endif
        .mem     (mem_if.master),
        .px      (px_if.master),
        .o_busy  (busy),
        .o_done  (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int key = 0;
    int rdy_mode = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [7:0] mem_val(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] s;
        s = a + ADDR_W'(key);
        return s[7:0];
    endfunction

    // Memory answers exactly one cycle after a read; otherwise it returns junk.
    always @(posedge clk) begin
        if (mem_if.en) mem_rdata <= mem_val(mem_if.addr);
        else           mem_rdata <= 8'($urandom);
    end

    // Downstream ready: 0 always high, 1 random 50%, other forced low.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       rdy = 1'b1;
            1:       rdy = 1'($urandom_range(0, 1));
            default: rdy = 1'b0;
        endcase
    end

    // Reference model and statistics.
    pix_t exp_q[$];
    pix_t log_q[$];
    pix_t p, act, prev_pix;
    logic model_busy = 1'b0, model_pat = 1'b0, done_due = 1'b0, prev_stall = 1'b0;
    logic eof_x, zero_start;
    int   cyc = 0, exp_addr = 0, issued = 0, popped = 0;
    int   xfer_cnt, eor_cnt, eof_cnt, en_cnt, vld_cnt, done_cnt;
    int   first_vld_cyc, first_xfer_cyc, last_xfer_cyc, start_cyc;

    task automatic clear_stats();
        xfer_cnt = 0; eor_cnt = 0; eof_cnt = 0; en_cnt = 0; vld_cnt = 0; done_cnt = 0;
        first_vld_cyc = -1; first_xfer_cyc = -1; last_xfer_cyc = -1; start_cyc = -1;
        log_q.delete();
    endtask

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            chk("rst_vld", 32'(px_if.vld), 32'd0);
            chk("rst_eor", 32'(px_if.eor), 32'd0);
            chk("rst_eof", 32'(px_if.eof), 32'd0);
            chk("rst_data", 32'(px_if.data), 32'd0);
            chk("rst_mem_en", 32'(mem_if.en), 32'd0);
            chk("rst_mem_addr", 32'(mem_if.addr), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            exp_q.delete();
            model_busy = 1'b0; done_due = 1'b0; prev_stall = 1'b0;
        end else begin
            chk("busy", 32'(busy), 32'(model_busy));
            chk("done", 32'(done), 32'(done_due));
            act = {px_if.eof, px_if.eor, px_if.data};
            if (prev_stall) begin
                chk("stall_vld", 32'(px_if.vld), 32'd1);
                chk("stall_hold", 32'(act), 32'(prev_pix));
            end
            eof_x = 1'b0;
            zero_start = 1'b0;
            if (mem_if.en) begin
                chk("mem_addr", 32'(mem_if.addr), 32'(exp_addr));
                chk("mem_en_in_pattern", 32'(model_pat), 32'd0);
                exp_addr++; issued++; en_cnt++;
            end
            if (px_if.vld) begin
                vld_cnt++;
                if (first_vld_cyc < 0) first_vld_cyc = cyc;
            end
            if (px_if.vld && rdy) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extra_pixel actual=%0h required=none", act);
                end else begin
                    p = exp_q.pop_front();
                    chk("pixel", 32'(act), 32'(p));
                    eof_x = p.eof;
                end
                popped++; xfer_cnt++;
                log_q.push_back(act);
                if (act.eor) eor_cnt++;
                if (act.eof) eof_cnt++;
                if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
                last_xfer_cyc = cyc;
            end
            chk("outstanding_le2", 32'((issued - popped) <= 2), 32'd1);
            if (done) done_cnt++;
            if (start && !model_busy) begin
                start_cyc = cyc;
                if (img_w == '0 || img_h == '0) begin
                    zero_start = 1'b1;
                end else begin
                    for (int r = 0; r < int'(img_h); r++) begin
                        for (int c = 0; c < int'(img_w); c++) begin
                            p.eor  = (c == int'(img_w) - 1);
                            p.eof  = (c == int'(img_w) - 1) && (r == int'(img_h) - 1);
                            p.data = pat_en ? 8'(c + r) : mem_val(ADDR_W'(r * int'(img_w) + c));
                            exp_q.push_back(p);
                        end
                    end
                    model_busy = 1'b1; model_pat = pat_en;
                    exp_addr = 0; issued = 0; popped = 0;
                end
            end
            done_due = eof_x || zero_start;
            if (eof_x) model_busy = 1'b0;
            prev_stall = px_if.vld && !rdy;
            prev_pix = act;
        end
    end

    task automatic start_frame(input int w, input int h);
        @(posedge clk); #1;
        img_w = CW'(w); img_h = HW'(h); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge clk); n++;
        end
        if (done_cnt == 0) begin
            checks++; errors++;
            $display("FAIL done_timeout actual=no_done required=done_within_%0d", budget);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int w, h, n;
        clear_stats();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // 4x3 at full rate, mem[a]=a
        key = 0; rdy_mode = 0; clear_stats();
        start_frame(4, 3);
        wait_done(100);
        chk("t1_xfers", 32'(xfer_cnt), 32'd12);
        chk("t1_reads", 32'(en_cnt), 32'd12);
        chk("t1_eor_cnt", 32'(eor_cnt), 32'd3);
        chk("t1_eof_cnt", 32'(eof_cnt), 32'd1);
        chk("t1_latency", 32'(first_vld_cyc - start_cyc), 32'd2);
        chk("t1_rate", 32'(last_xfer_cyc - first_xfer_cyc), 32'd11);
        chk("t1_first", 32'(log_q[0]), 32'h000);
        chk("t1_pix3", 32'(log_q[3]), 32'h103);
        chk("t1_pix7", 32'(log_q[7]), 32'h107);
        chk("t1_pix11", 32'(log_q[11]), 32'h30b);
        chk("t1_done_cnt", 32'(done_cnt), 32'd1);

        // random stalls, first a 4x3 then random sizes and contents
        rdy_mode = 1;
        for (int it = 0; it < 6; it++) begin
            key = int'($urandom_range(0, 255));
            w = (it == 0) ? 4 : int'($urandom_range(1, 8));
            h = (it == 0) ? 3 : int'($urandom_range(1, 6));
            clear_stats();
            start_frame(w, h);
            wait_done(600);
            chk("t2_xfers", 32'(xfer_cnt), 32'(w * h));
            chk("t2_eor_cnt", 32'(eor_cnt), 32'(h));
            chk("t2_eof_cnt", 32'(eof_cnt), 32'd1);
        end

        // W=1 column, then zero-sized frames
        rdy_mode = 0; key = 7; clear_stats();
        start_frame(1, 3);
        wait_done(50);
        chk("t3_xfers", 32'(xfer_cnt), 32'd3);
        chk("t3_eor_cnt", 32'(eor_cnt), 32'd3);
        chk("t3_eof_last", 32'(log_q[2].eof), 32'd1);
        chk("t3_eof_cnt", 32'(eof_cnt), 32'd1);
        for (int z = 0; z < 2; z++) begin
            clear_stats();
            if (z == 0) start_frame(0, 5);
            else        start_frame(7, 0);
            wait_done(20);
            chk("t3z_vld", 32'(vld_cnt), 32'd0);
            chk("t3z_reads", 32'(en_cnt), 32'd0);
            chk("t3z_done_cnt", 32'(done_cnt), 32'd1);
        end

        // 640x2 with an initial stall and an ignored mid-frame start
        key = int'($urandom_range(0, 255)); rdy_mode = 2; clear_stats();
        start_frame(640, 2);
        n = 0;
        while (vld_cnt == 0 && n < 20) begin
            @(posedge clk); n++;
        end
        chk("t4_vld_seen", 32'(vld_cnt > 0), 32'd1);
        repeat (10) @(posedge clk);
        #1 rdy_mode = 0;
        repeat (50) @(posedge clk);
        start_frame(3, 3);
        wait_done(2000);
        chk("t4_xfers", 32'(xfer_cnt), 32'd1280);
        chk("t4_eor_cnt", 32'(eor_cnt), 32'd2);
        chk("t4_eof_cnt", 32'(eof_cnt), 32'd1);
        chk("t4_done_cnt", 32'(done_cnt), 32'd1);
        chk("t4_reads", 32'(en_cnt), 32'd1280);

        // reset after 5 transfers, then a fresh 2x2
        key = 0; rdy_mode = 0; clear_stats();
        start_frame(4, 3);
        n = 0;
        while (xfer_cnt < 5 && n < 50) begin
            @(negedge clk); n++;
        end
        chk("t5_five_xfers", 32'(xfer_cnt >= 5), 32'd1);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        chk("t5_no_done", 32'(done_cnt), 32'd0);
        clear_stats();
        start_frame(2, 2);
        wait_done(50);
        chk("t5_xfers", 32'(xfer_cnt), 32'd4);
        chk("t5_pix0", 32'(log_q[0]), 32'h000);
        chk("t5_pix1", 32'(log_q[1]), 32'h101);
        chk("t5_pix3", 32'(log_q[3]), 32'h303);
        chk("t5_eof_cnt", 32'(eof_cnt), 32'd1);

`ifdef PIXEL_TX_PATTERN_EN
        // pattern source: data = col+row, no memory traffic
        key = 99; rdy_mode = 1; pat_en = 1'b1; clear_stats();
        start_frame(3, 2);
        wait_done(100);
        pat_en = 1'b0;
        chk("t6_xfers", 32'(xfer_cnt), 32'd6);
        chk("t6_reads", 32'(en_cnt), 32'd0);
        chk("t6_d0", 32'(log_q[0].data), 32'd0);
        chk("t6_d2", 32'(log_q[2]), 32'h102);
        chk("t6_d3", 32'(log_q[3].data), 32'd1);
        chk("t6_d5", 32'(log_q[5]), 32'h303);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
